cart_banked_sram_mapper: RTL and testbench
==========================================

// Module: cart_banked_sram_mapper
// PURPOSE
//  Parametrised MSX cartridge bank mapper with battery-backed SRAM and save tracking.
//  Sits between the slot decoder (cs) and the SDRAM/BRAM cartridge stores.
//  Generalises the fixed 4x8KB SRAM mapper: the window size, window count, SRAM page size and first-window lock are all parameters.
//  Adds edge-qualified register and SRAM writes, and an idle-timeout save request handshake toward the HPS.
// PARAMETERS
//  WIN_LOG2      13         window size log2 (13=8KB, 14=16KB); the 32KB area 4000h-BFFFh is split into windows
//  NUM_WIN       4          number of windows; must equal 2**(15-WIN_LOG2)
//  BANK_W        8          width of each bank register
//  SRAM_SEL_BIT  4          bank bit that maps SRAM instead of ROM
//  SRAM_ADDR_W   13         sram_addr width: MSB is bank[SRAM_SEL_BIT+1], the rest is addr[SRAM_ADDR_W-2:0]
//  FIXED_FIRST   1          1: window 0 is hard-wired to bank 0 and has no register
//  SAVE_TIMEOUT  1000000    idle clk cycles after the last SRAM write before save_req is raised
// PORTS
//  clk          in   1            system clock
//  reset_n      in   1            asynchronous, active-low reset
//  addr         in   16           CPU address
//  d_from_cpu   in   8            CPU write data
//  wr           in   1            CPU write (level; may be held for several cycles)
//  cs           in   1            cartridge slot select
//  mem_addr     out  25           ROM byte address = {0, bank[ROM bits], addr[WIN_LOG2-1:0]}
//  sram_addr    out  SRAM_ADDR_W  SRAM byte address
//  sram_oe      out  1            cs and the current window maps SRAM
//  sram_we      out  1            single-cycle SRAM write strobe
//  dirty        out  1            SRAM has been modified since the last acknowledged save
//  save_req     out  1            request to the HPS to save SRAM; held until save_ack
//  save_ack     in   1            HPS save done; single-cycle pulse
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  - Reset: bank[i]=i; wr_q=0; dirty=0; save_req=0; timer=0; FSM=IDLE; sram_we=0.
//  - Window index w = (addr-16'h4000)>>WIN_LOG2, valid for 4000h-BFFFh. Outside that range mem_addr uses w=0 and sram_oe/sram_we=0.
//  - Write strobe: wstb = cs & wr & ~wr_q, where wr_q is cs&wr registered. A held wr produces exactly one strobe.
//  - Bank register write: wstb in the lower half of window w (addr[WIN_LOG2-1]==0) with w!=0 or FIXED_FIRST==0 -> bank[w] <= d_from_cpu[BANK_W-1:0].
//    The register updates on the clock edge after the strobe; the new mapping is visible from that cycle.
//  - mem_addr, sram_addr and sram_oe are combinational from addr and the bank registers (zero latency).
//    ROM bank bits are bank[SRAM_SEL_BIT-1:0].
//  - sram_we = wstb & window NUM_WIN-1 & addr[WIN_LOG2-1]==1 & bank[NUM_WIN-1][SRAM_SEL_BIT].
//    This is combinational from wstb and is high for 1 cycle.
//    A write to the upper half of any other window is ignored.
//  - Save FSM (cart_save_timer):
//    IDLE  --sram_we-->                  DIRTY  (dirty=1, timer=SAVE_TIMEOUT-1)
//    DIRTY --sram_we-->                  DIRTY  (timer reloads)
//    DIRTY --timer==0-->                 REQ    (save_req=1 registered)
//    DIRTY otherwise: timer decrements by 1 per cycle.
//    REQ   --save_ack & no sram_we that cycle--> IDLE  (dirty=0, save_req=0)
//    REQ   --sram_we (with or without ack)-->   stay in REQ with rewrite=1
//    REQ   --save_ack & rewrite-->              DIRTY (dirty stays 1, timer reloads, save_req=0, rewrite cleared)
//  - save_ack outside REQ is ignored.
//  - Reset asserted mid-REQ drops save_req immediately (asynchronous).
//  - Timer width is $clog2(SAVE_TIMEOUT+1). SAVE_TIMEOUT=1 gives save_req on the 2nd cycle after the write.
// STRUCTURE
//  cart_pkg: CART_WIN_BASE=16'h4000, MEM_ADDR_W=25, save FSM state enum {IDLE,DIRTY,REQ}.
//  Sub-module cart_save_timer (params: SAVE_TIMEOUT; ports: clk, reset_n, wr_pulse, save_ack, dirty, save_req).
//  Top: bank register array, write edge detect, address muxing.
// TESTING
//  1 Reset, default params; read 6000h -> mem_addr=25'h2000; read A000h -> 25'h6000; sram_oe=0; dirty=0.
//  2 Write 12h to 8000h with wr held 3 cycles -> exactly one bank update; then read 9ABCh -> mem_addr=25'h5ABC.
//  3 Write 10h to A000h, then write 55h to B123h with wr held 4 cycles -> sram_we high for 1 cycle, sram_addr=13'h0123, dirty=1.
//    Write 30h to A000h -> sram_addr MSB=1.
//  4 SAVE_TIMEOUT=8: one SRAM write -> save_req rises 9 cycles later; save_ack -> save_req=0 and dirty=0 the next cycle.
//  5 While in REQ, do an SRAM write and then save_ack -> save_req drops and dirty stays 1; save_req rises again SAVE_TIMEOUT+1 cycles later.
//  6 WIN_LOG2=14, NUM_WIN=2, FIXED_FIRST=0: write 03h to 4000h -> read 4001h gives mem_addr=25'hC001; write to 6000h changes no bank register.
//    Pull reset_n low during REQ -> save_req=0 immediately and all banks return to i.

Source files
------------

// File: rtl/cart_pkg.sv
// Shared constants and save-state encoding for the banked cartridge SRAM mapper.
package cart_pkg;

    localparam logic [15:0] CART_WIN_BASE = 16'h4000;
    localparam logic [15:0] CART_WIN_END  = 16'hC000;
    localparam int          MEM_ADDR_W    = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIRTY = 2'd1,
        REQ   = 2'd2
    } save_state_e;

endpackage

// File: rtl/cart_save_timer.sv
// Tracks SRAM modification and raises a save request after an idle period.
module cart_save_timer
    import cart_pkg::*;
#(
    parameter int SAVE_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_pulse,
    input  logic        save_ack,
    output logic        dirty,
    output logic        save_req,
    output save_state_e state_dbg
);

    localparam int TW = $clog2(SAVE_TIMEOUT + 1);
    localparam logic [TW-1:0] RELOAD = TW'(SAVE_TIMEOUT - 1);

    save_state_e   r_state;
    logic [TW-1:0] r_timer;
    logic          r_dirty;
    logic          r_save_req;
    logic          r_rewrite;

    // save_req rises registered and stays high until a single-cycle save_ack
    // is seen in REQ; an SRAM write during REQ makes that ack restart the
    // idle timer instead of clearing dirty, because the saved image is stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_dirty    <= 1'b0;
            r_save_req <= 1'b0;
            r_rewrite  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wr_pulse) begin
                        r_state <= DIRTY;
                        r_dirty <= 1'b1;
                        r_timer <= RELOAD;
                    end
                end
                DIRTY: begin
                    if (wr_pulse) begin
                        r_timer <= RELOAD;
                    end else if (r_timer == '0) begin
                        r_state    <= REQ;
                        r_save_req <= 1'b1;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                REQ: begin
                    if (wr_pulse) begin
                        r_rewrite <= 1'b1;
                    end else if (save_ack) begin
                        r_save_req <= 1'b0;
                        r_rewrite  <= 1'b0;
                        if (r_rewrite) begin
                            r_state <= DIRTY;
                            r_timer <= RELOAD;
                        end else begin
                            r_state <= IDLE;
                            r_dirty <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dirty     = r_dirty;
    assign save_req  = r_save_req;
    assign state_dbg = r_state;

endmodule

// File: rtl/cart_banked_sram_mapper.sv
// MSX cartridge bank mapper: banked ROM windows, one SRAM-capable window, save tracking.
module cart_banked_sram_mapper
    import cart_pkg::*;
#(
    parameter int WIN_LOG2     = 13,
    parameter int NUM_WIN      = 4,
    parameter int BANK_W       = 8,
    parameter int SRAM_SEL_BIT = 4,
    parameter int SRAM_ADDR_W  = 13,
    parameter int FIXED_FIRST  = 1,
    parameter int SAVE_TIMEOUT = 1000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [15:0]            addr,
    input  logic [7:0]             d_from_cpu,
    input  logic                   wr,
    input  logic                   cs,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_oe,
    output logic                   sram_we,
    output logic                   dirty,
    output logic                   save_req,
    input  logic                   save_ack,
    output save_state_e            save_state
);

    localparam int WIN_W = 15 - WIN_LOG2;

    logic [15:0]       w_off;
    logic              w_in_range;
    logic [WIN_W-1:0]  w_win;
    logic              w_upper;
    logic [BANK_W-1:0] w_bank [NUM_WIN];
    logic [BANK_W-1:0] w_cur_bank;
    logic              r_wr_q;
    logic              w_wstb;
    logic              w_reg_wr;
    logic              w_unused_bits;

    assign w_off      = addr - CART_WIN_BASE;
    assign w_in_range = (addr >= CART_WIN_BASE) && (addr < CART_WIN_END);
    assign w_win      = w_in_range ? w_off[14:WIN_LOG2] : '0;
    assign w_upper    = addr[WIN_LOG2-1];
    assign w_cur_bank = w_bank[w_win];

    // A held wr yields one strobe; wr_q only re-arms once cs&wr drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_q <= 1'b0;
        end else begin
            r_wr_q <= cs & wr;
        end
    end

    assign w_wstb   = cs & wr & ~r_wr_q;
    assign w_reg_wr = w_wstb & w_in_range & ~w_upper;

    for (genvar i = 0; i < NUM_WIN; i++) begin : g_bank
        if (FIXED_FIRST != 0 && i == 0) begin : g_fixed
            assign w_bank[i] = '0;
        end else begin : g_reg
            logic [BANK_W-1:0] r_bank;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_bank <= BANK_W'(i);
                end else if (w_reg_wr && (w_win == WIN_W'(i))) begin
                    r_bank <= d_from_cpu[BANK_W-1:0];
                end
            end
            assign w_bank[i] = r_bank;
        end
    end

    assign mem_addr  = {{(MEM_ADDR_W - SRAM_SEL_BIT - WIN_LOG2){1'b0}},
                        w_cur_bank[SRAM_SEL_BIT-1:0], addr[WIN_LOG2-1:0]};
    assign sram_addr = {w_cur_bank[SRAM_SEL_BIT+1], addr[SRAM_ADDR_W-2:0]};
    assign sram_oe   = cs & w_in_range & w_cur_bank[SRAM_SEL_BIT];

    // Only the upper half of the last window accepts SRAM writes.
    assign sram_we = w_wstb & w_in_range & w_upper
                   & (w_win == WIN_W'(NUM_WIN - 1))
                   & w_bank[NUM_WIN-1][SRAM_SEL_BIT];

    assign w_unused_bits = ^{w_off[15], w_off[WIN_LOG2-1:0],
                             w_cur_bank[BANK_W-1:SRAM_SEL_BIT+2]};

    cart_save_timer #(
        .SAVE_TIMEOUT(SAVE_TIMEOUT)
    ) u_save_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_pulse (sram_we),
        .save_ack (save_ack),
        .dirty    (dirty),
        .save_req (save_req),
        .state_dbg(save_state)
    );

endmodule

// File: tb/tb_cart_banked_sram_mapper.sv
// Bench: default-geometry mapper (A) and a 2x16KB unlocked mapper (B), checked against a model.
module tb_cart_banked_sram_mapper;
    import cart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT A: 4 x 8KB, window 0 fixed, SAVE_TIMEOUT=8
    logic        a_rst_n, a_wr, a_cs, a_ack;
    logic [15:0] a_addr;
    logic [7:0]  a_din;
    logic [24:0] a_mem_addr;
    logic [12:0] a_sram_addr;
    logic        a_sram_oe, a_sram_we, a_dirty, a_save_req;
    save_state_e a_state;

    // DUT B: 2 x 16KB, no fixed window, SAVE_TIMEOUT=4
    logic        b_rst_n, b_wr, b_cs, b_ack;
    logic [15:0] b_addr;
    logic [7:0]  b_din;
    logic [24:0] b_mem_addr;
    logic [12:0] b_sram_addr;
    logic        b_sram_oe, b_sram_we, b_dirty, b_save_req;
    save_state_e b_state;

    cart_banked_sram_mapper #(.SAVE_TIMEOUT(8)) dut_a (
        .clk(clk), .reset_n(a_rst_n), .addr(a_addr), .d_from_cpu(a_din),
        .wr(a_wr), .cs(a_cs), .mem_addr(a_mem_addr), .sram_addr(a_sram_addr),
        .sram_oe(a_sram_oe), .sram_we(a_sram_we), .dirty(a_dirty),
        .save_req(a_save_req), .save_ack(a_ack), .save_state(a_state)
    );

    cart_banked_sram_mapper #(.WIN_LOG2(14), .NUM_WIN(2), .FIXED_FIRST(0),
                              .SAVE_TIMEOUT(4)) dut_b (
        .clk(clk), .reset_n(b_rst_n), .addr(b_addr), .d_from_cpu(b_din),
        .wr(b_wr), .cs(b_cs), .mem_addr(b_mem_addr), .sram_addr(b_sram_addr),
        .sram_oe(b_sram_oe), .sram_we(b_sram_we), .dirty(b_dirty),
        .save_req(b_save_req), .save_ack(b_ack), .save_state(b_state)
    );

    // Reference model for DUT A: bank contents and dirty flag.
    int m_bank[4];
    bit m_dirty;

    function automatic bit m_inr(input int ad);
        return (ad >= 'h4000) && (ad < 'hC000);
    endfunction

    function automatic int m_win(input int ad);
        return m_inr(ad) ? (ad - 'h4000) / 8192 : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_bank[i] = i;
        m_bank[0] = 0;
        m_dirty = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel_b, input logic [15:0] ad, input logic [7:0] d,
                         input logic cs, input logic wr);
        if (sel_b) begin
            b_addr = ad; b_din = d; b_cs = cs; b_wr = wr;
        end else begin
            a_addr = ad; a_din = d; a_cs = cs; a_wr = wr;
        end
    endtask

    // Holds wr for 'hold' cycles, counts sram_we cycles, then one idle cycle.
    task automatic do_write(input bit sel_b, input logic [15:0] ad, input logic [7:0] d,
                            input int hold, input logic cs, output int pulses);
        drive(sel_b, ad, d, cs, 1'b1);
        pulses = 0;
        repeat (hold) begin
            @(negedge clk);
            if ((sel_b ? b_sram_we : a_sram_we) === 1'b1) pulses++;
            tick();
        end
        drive(sel_b, ad, d, cs, 1'b0);
        tick();
    endtask

    task automatic settle(input bit sel_b, input logic [15:0] ad, input logic cs);
        drive(sel_b, ad, 8'h00, cs, 1'b0);
        @(negedge clk);
    endtask

    // Cycle index at which save_req is seen high, counting from 'start'; -1 on timeout.
    task automatic wait_rise(input bit sel_b, input int start, output int idx);
        idx = -1;
        for (int n = start; n < start + 40; n++) begin
            @(negedge clk);
            if ((sel_b ? b_save_req : a_save_req) === 1'b1) begin
                idx = n;
                break;
            end
            tick();
        end
    endtask

    task automatic reset_a();
        a_rst_n = 1'b0;
        tick(); tick();
        a_rst_n = 1'b1;
        tick();
        m_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, idx, ad, d, cs_i, hold, w, exp_p;
        bit upper;

        a_rst_n = 1'b0; a_wr = 1'b0; a_cs = 1'b0; a_ack = 1'b0; a_addr = '0; a_din = '0;
        b_rst_n = 1'b0; b_wr = 1'b0; b_cs = 1'b0; b_ack = 1'b0; b_addr = '0; b_din = '0;
        m_reset();
        tick(); tick();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();

        // 1: reset mapping
        settle(0, 16'h6000, 1'b1);
        check("rst_mem_6000", 32'(a_mem_addr), 32'h2000);
        check("rst_oe_6000", 32'(a_sram_oe), 0);
        check("rst_dirty", 32'(a_dirty), 0);
        check("rst_save_req", 32'(a_save_req), 0);
        check("rst_state", 32'(a_state), 32'(IDLE));
        settle(0, 16'hA000, 1'b1);
        check("rst_mem_A000", 32'(a_mem_addr), 32'h6000);
        check("rst_oe_A000", 32'(a_sram_oe), 0);
        tick();

        // 2: held write with changing data latches only the first byte
        drive(0, 16'h8000, 8'h12, 1'b1, 1'b1);
        tick(); a_din = 8'h77;
        tick(); a_din = 8'h66;
        tick(); a_wr = 1'b0;
        tick();
        m_bank[2] = 'h12;
        settle(0, 16'h9ABC, 1'b1);
        check("bank2_mem_9ABC", 32'(a_mem_addr), 32'h5ABC);
        tick();

        // 3: SRAM mapping and single-cycle write strobe
        do_write(0, 16'hA000, 8'h10, 1, 1'b1, p);
        check("bank3_wr_pulses", p, 0);
        do_write(0, 16'hB123, 8'h55, 4, 1'b1, p);
        check("sram_we_pulses", p, 1);
        settle(0, 16'hB123, 1'b1);
        check("sram_addr_B123", 32'(a_sram_addr), 32'h0123);
        check("sram_oe_B123", 32'(a_sram_oe), 1);
        check("dirty_after_wr", 32'(a_dirty), 1);
        tick();
        do_write(0, 16'hA000, 8'h30, 1, 1'b1, p);
        settle(0, 16'hB123, 1'b1);
        check("sram_addr_msb", 32'(a_sram_addr), 32'h1123);
        tick();

        // 4: save request latency and acknowledge
        reset_a();
        do_write(0, 16'hA000, 8'h10, 1, 1'b1, p);
        do_write(0, 16'hB000, 8'h01, 1, 1'b1, p);
        check("t4_pulse", p, 1);
        wait_rise(0, 2, idx);
        check("t4_req_latency", idx, 9);
        tick();
        a_ack = 1'b1; tick(); a_ack = 1'b0;
        @(negedge clk);
        check("t4_req_after_ack", 32'(a_save_req), 0);
        check("t4_dirty_after_ack", 32'(a_dirty), 0);
        check("t4_state_after_ack", 32'(a_state), 32'(IDLE));
        tick();

        // 5: rewrite during REQ restarts the timer
        do_write(0, 16'hB010, 8'h02, 1, 1'b1, p);
        wait_rise(0, 2, idx);
        check("t5_req_latency", idx, 9);
        tick();
        do_write(0, 16'hB020, 8'h03, 1, 1'b1, p);
        check("t5_req_pulse", p, 1);
        @(negedge clk);
        check("t5_req_held", 32'(a_save_req), 1);
        tick();
        a_ack = 1'b1; tick(); a_ack = 1'b0;
        @(negedge clk);
        check("t5_req_dropped", 32'(a_save_req), 0);
        check("t5_dirty_kept", 32'(a_dirty), 1);
        tick();
        wait_rise(0, 2, idx);
        check("t5_req_relatency", idx, 9);
        tick();

        // Randomised mixed traffic on A against the model
        reset_a();
        for (int it = 0; it < 120; it++) begin
            int op;
            op = $urandom_range(0, 2);
            ad = (op == 2) ? ('hA000 + $urandom_range(0, 'h1FFF)) : $urandom_range(0, 'hFFFF);
            d  = $urandom_range(0, 255);
            w  = m_win(ad);
            upper = (ad % 8192) >= 4096;
            if (op == 0) begin
                cs_i = $urandom_range(0, 1);
                settle(0, 16'(ad), 1'(cs_i));
                check("rnd_mem", 32'(a_mem_addr), 32'((m_bank[w] % 16) * 8192 + ad % 8192));
                check("rnd_oe", 32'(a_sram_oe), 32'(cs_i != 0 && m_inr(ad) && ((m_bank[w] >> 4) & 1) != 0));
                check("rnd_sram_addr", 32'(a_sram_addr), 32'(((m_bank[w] >> 5) & 1) * 4096 + ad % 4096));
                tick();
            end else begin
                cs_i = ($urandom_range(0, 7) != 0);
                hold = $urandom_range(1, 3);
                exp_p = (cs_i != 0 && m_inr(ad) && upper && w == 3 && ((m_bank[3] >> 4) & 1) != 0);
                do_write(0, 16'(ad), 8'(d), hold, 1'(cs_i), p);
                if (cs_i != 0 && m_inr(ad) && !upper && w != 0) m_bank[w] = d;
                if (exp_p != 0) m_dirty = 1'b1;
                check("rnd_we_pulses", p, exp_p);
                @(negedge clk);
                check("rnd_dirty", 32'(a_dirty), 32'(m_dirty));
                tick();
            end
        end

        // 6: 2 x 16KB geometry, unlocked window 0
        do_write(1, 16'h4000, 8'h03, 1, 1'b1, p);
        check("b_w0_pulses", p, 0);
        settle(1, 16'h4001, 1'b1);
        check("b_mem_4001", 32'(b_mem_addr), 32'hC001);
        tick();
        do_write(1, 16'h6000, 8'h55, 1, 1'b1, p);
        check("b_upper_w0_pulses", p, 0);
        settle(1, 16'h4001, 1'b1);
        check("b_mem_4001_kept", 32'(b_mem_addr), 32'hC001);
        settle(1, 16'h8001, 1'b1);
        check("b_mem_8001_kept", 32'(b_mem_addr), 32'h4001);
        tick();
        do_write(1, 16'h8000, 8'h10, 1, 1'b1, p);
        do_write(1, 16'hA005, 8'hAA, 1, 1'b1, p);
        check("b_sram_pulse", p, 1);
        wait_rise(1, 2, idx);
        check("b_req_latency", idx, 5);
        b_rst_n = 1'b0;
        #1;
        check("b_req_async_rst", 32'(b_save_req), 0);
        check("b_dirty_async_rst", 32'(b_dirty), 0);
        settle(1, 16'h4001, 1'b1);
        check("b_rst_mem_4001", 32'(b_mem_addr), 32'h0001);
        settle(1, 16'h8001, 1'b1);
        check("b_rst_mem_8001", 32'(b_mem_addr), 32'h4001);
        tick();
        b_rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
